// File: rtl/gene_mutator.sv
// gene_mutator: consumer side of the mutation-mask handshake.
// Waits for a valid mask set, streams parent genes through XOR with their masks
// into the child population, then holds maskUsed until the generator withdraws
// maskReady.
module gene_mutator #(
    parameter int unsigned geneBit           = 80,
    parameter int unsigned mutationMaskCount = 16,
    parameter int unsigned idxBit            = 4,
    parameter int unsigned elite             = 1,
    parameter int unsigned countBit          = 12
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                start,
    input  logic                maskReady,
    output logic                maskUsed,
    output logic [idxBit-1:0]   gene_rd_addr,
    input  logic [geneBit-1:0]  gene_rd_data,
    output logic [idxBit-1:0]   mask_rd_addr,
    input  logic [geneBit-1:0]  mask_rd_data,
    output logic                child_wr_en,
    output logic [idxBit-1:0]   child_wr_addr,
    output logic [geneBit-1:0]  child_wr_data,
    output logic                busy,
    output logic                done,
    output logic [countBit-1:0] mutBitTotal
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitMask,
        StRead,
        StApply,
        StRelease,
        StDone
    } state_e;

    localparam logic [idxBit-1:0] LastIdx = idxBit'(mutationMaskCount - 1);

    state_e              state_q, state_d;
    logic [idxBit-1:0]   idx_q, idx_d;
    logic [countBit-1:0] total_q, total_d;
    logic [geneBit-1:0]  applied_mask;

    function automatic logic [countBit-1:0] popcount(input logic [geneBit-1:0] v);
        logic [countBit-1:0] n;
        n = '0;
        for (int i = 0; i < geneBit; i++) begin
            n = n + countBit'(v[i]);
        end
        return n;
    endfunction

    // State, index and running bit total registers
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            total_q <= total_d;
        end
    end

    // Datapath: the elite gene passes through with its mask suppressed
    always_comb begin
        applied_mask = mask_rd_data;
        if ((elite != 0) && (idx_q == '0)) begin
            applied_mask = '0;
        end
        child_wr_data = gene_rd_data ^ applied_mask;
        child_wr_addr = idx_q;
        gene_rd_addr  = idx_q;
        mask_rd_addr  = idx_q;
    end

    // Status outputs decoded straight from the state register
    always_comb begin
        child_wr_en = (state_q == StApply);
        maskUsed    = (state_q == StRelease);
        busy        = (state_q != StIdle);
        done        = (state_q == StDone);
        mutBitTotal = total_q;
    end

    // Next-state logic; start is only honoured in idle
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        total_d = total_q;
        case (state_q)
            StIdle: begin
                idx_d = '0;
                if (start) begin
                    state_d = StWaitMask;
                    // total survives in idle until a new generation is accepted
                    total_d = '0;
                end
            end
            StWaitMask: begin
                if (maskReady) begin
                    state_d = StRead;
                end
            end
            StRead: begin
                // address presented this cycle, data arrives in apply
                state_d = StApply;
            end
            StApply: begin
                total_d = total_q + popcount(applied_mask);
                if (idx_q == LastIdx) begin
                    state_d = StRelease;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StRead;
                end
            end
            StRelease: begin
                if (!maskReady) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_gene_mutator.sv
// Bench for gene_mutator: two instances (elite off / on) run in lockstep against
// behavioural one-cycle memories; child writes are checked against a queue of
// expected writes filled when each generation is launched.
module tb_gene_mutator;

    localparam int GB = 80;
    localparam int N  = 16;
    localparam int IB = 4;
    localparam int CB = 12;

    typedef struct packed {
        logic [IB-1:0] addr;
        logic [GB-1:0] data;
    } wr_t;

    logic          CLOCK_50 = 1'b0;
    logic          reset;
    logic          start;
    logic          maskReady;
    logic          mask_used [2];
    logic          busy      [2];
    logic          done      [2];
    logic          wr_en     [2];
    logic [IB-1:0] g_addr    [2];
    logic [IB-1:0] m_addr    [2];
    logic [IB-1:0] wr_addr   [2];
    logic [GB-1:0] g_data    [2];
    logic [GB-1:0] m_data    [2];
    logic [GB-1:0] wr_data   [2];
    logic [CB-1:0] total     [2];

    logic [GB-1:0] parent [N];
    logic [GB-1:0] mask   [N];
    logic [CB-1:0] exp_total [2];
    wr_t           q0 [$];
    wr_t           q1 [$];
    wr_t           mon_e;
    int            wr_cnt [2];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            n_fail   = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    gene_mutator #(
        .geneBit(GB), .mutationMaskCount(N), .idxBit(IB), .elite(0), .countBit(CB)
    ) u_dut0 (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .start        (start),
        .maskReady    (maskReady),
        .maskUsed     (mask_used[0]),
        .gene_rd_addr (g_addr[0]),
        .gene_rd_data (g_data[0]),
        .mask_rd_addr (m_addr[0]),
        .mask_rd_data (m_data[0]),
        .child_wr_en  (wr_en[0]),
        .child_wr_addr(wr_addr[0]),
        .child_wr_data(wr_data[0]),
        .busy         (busy[0]),
        .done         (done[0]),
        .mutBitTotal  (total[0])
    );

    gene_mutator #(
        .geneBit(GB), .mutationMaskCount(N), .idxBit(IB), .elite(1), .countBit(CB)
    ) u_dut1 (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .start        (start),
        .maskReady    (maskReady),
        .maskUsed     (mask_used[1]),
        .gene_rd_addr (g_addr[1]),
        .gene_rd_data (g_data[1]),
        .mask_rd_addr (m_addr[1]),
        .mask_rd_data (m_data[1]),
        .child_wr_en  (wr_en[1]),
        .child_wr_addr(wr_addr[1]),
        .child_wr_data(wr_data[1]),
        .busy         (busy[1]),
        .done         (done[1]),
        .mutBitTotal  (total[1])
    );

    // One-cycle-latency parent and mask memories, one read port per instance
    always @(posedge CLOCK_50) begin
        for (int d = 0; d < 2; d++) begin
            g_data[d] <= parent[g_addr[d]];
            m_data[d] <= mask[m_addr[d]];
        end
    end

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Scoreboard: every child write must match the oldest queued expectation
    always @(negedge CLOCK_50) begin
        for (int d = 0; d < 2; d++) begin
            if (wr_en[d] === 1'b1) begin
                wr_cnt[d]++;
                chk($sformatf("wr_expected_d%0d", d),
                    128'(((d == 0) ? q0.size() : q1.size()) != 0), 128'(1));
                if ((d == 0) && (q0.size() != 0)) begin
                    mon_e = q0.pop_front();
                end else if ((d == 1) && (q1.size() != 0)) begin
                    mon_e = q1.pop_front();
                end else begin
                    mon_e = '0;
                end
                chk($sformatf("wr_addr_d%0d", d), 128'(wr_addr[d]), 128'(mon_e.addr));
                chk($sformatf("wr_data_d%0d_i%0d", d, mon_e.addr), 128'(wr_data[d]),
                    128'(mon_e.data));
            end
        end
    end

    // Queue expected writes for genes 0..upto-1 and compute expected totals
    task automatic push_exp(input int upto);
        wr_t e;
        exp_total[0] = '0;
        exp_total[1] = '0;
        for (int i = 0; i < upto; i++) begin
            e.addr = IB'(i);
            e.data = parent[i] ^ mask[i];
            q0.push_back(e);
            exp_total[0] = exp_total[0] + CB'($countones(mask[i]));
            e.data = (i == 0) ? parent[i] : (parent[i] ^ mask[i]);
            q1.push_back(e);
            if (i != 0) exp_total[1] = exp_total[1] + CB'($countones(mask[i]));
        end
    endtask

    // One generation; generator lowers maskReady once maskUsed has been seen 'hold' cycles
    task automatic do_gen(input string tag, input int hold, input int rdelay, input bit inject);
        int used_cnt;
        int done_it;
        wr_cnt[0] = 0;
        wr_cnt[1] = 0;
        push_exp(N);
        maskReady = (rdelay == 0);
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        used_cnt = 0;
        done_it  = -1;
        for (int j = 1; j <= 200; j++) begin
            @(negedge CLOCK_50);
            start = 1'b0;
            if ((rdelay > 0) && (j <= rdelay + 1)) begin
                chk({tag, "_wait_busy"}, 128'(busy[1]), 128'(1));
                chk({tag, "_wait_nowr"}, 128'(wr_en[1]), 128'(0));
            end
            if ((rdelay > 0) && (j == rdelay + 2)) begin
                chk({tag, "_first_wr"}, 128'(wr_en[1]), 128'(1));
            end
            if ((rdelay > 0) && (j == rdelay)) maskReady = 1'b1;
            if (inject && (j == rdelay + 3)) start = 1'b1;
            if (mask_used[1] === 1'b1) begin
                used_cnt++;
                if (inject && (used_cnt == 1)) start = 1'b1;
                if (used_cnt == hold) maskReady = 1'b0;
            end
            if (done[1] === 1'b1) begin
                done_it = j;
                chk({tag, "_done_lockstep"}, 128'(done[0]), 128'(1));
                break;
            end
        end
        chk({tag, "_done_cycle"}, 128'(done_it), 128'(33 + hold + rdelay));
        chk({tag, "_used_cycles"}, 128'(used_cnt), 128'(hold));
        for (int k = 0; k < 3; k++) begin
            @(negedge CLOCK_50);
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("%s_after_done_d%0d", tag, d), 128'(done[d]), 128'(0));
                chk($sformatf("%s_idle_busy_d%0d", tag, d), 128'(busy[d]), 128'(0));
            end
        end
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_total_d%0d", tag, d), 128'(total[d]), 128'(exp_total[d]));
            chk($sformatf("%s_writes_d%0d", tag, d), 128'(wr_cnt[d]), 128'(N));
        end
        chk({tag, "_q_empty"}, 128'(q0.size() + q1.size()), 128'(0));
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        maskReady = 1'b0;
        wr_cnt[0] = 0;
        wr_cnt[1] = 0;
        for (int i = 0; i < N; i++) begin
            parent[i] = GB'(i);
            mask[i]   = GB'(1) << i;
        end
        repeat (3) @(negedge CLOCK_50);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_busy_d%0d", d), 128'(busy[d]), 128'(0));
            chk($sformatf("rst_done_d%0d", d), 128'(done[d]), 128'(0));
            chk($sformatf("rst_used_d%0d", d), 128'(mask_used[d]), 128'(0));
            chk($sformatf("rst_wr_en_d%0d", d), 128'(wr_en[d]), 128'(0));
            chk($sformatf("rst_total_d%0d", d), 128'(total[d]), 128'(0));
        end
        reset = 1'b0;
        @(negedge CLOCK_50);

        // Walking-one masks, mask preset, companion-style release
        do_gen("walk", 3, 0, 1'b0);

        // Random data, mask set arrives 20 cycles after start
        for (int i = 0; i < N; i++) begin
            parent[i] = GB'({$urandom(), $urandom(), $urandom()});
            mask[i]   = GB'({$urandom(), $urandom(), $urandom()}) &
                        GB'({$urandom(), $urandom(), $urandom()});
        end
        do_gen("late", 2, 20, 1'b0);

        // Longer release and start pulses while busy
        for (int i = 0; i < N; i++) begin
            parent[i] = GB'({$urandom(), $urandom(), $urandom()});
            mask[i]   = GB'({$urandom(), $urandom(), $urandom()});
        end
        do_gen("hold5", 5, 0, 1'b1);

        // All-ones masks invert every non-elite gene
        for (int i = 0; i < N; i++) mask[i] = '1;
        do_gen("ones", 4, 0, 1'b0);
        chk("ones_total_1280", 128'(total[0]), 128'(1280));

        // Reset during apply of idx 7, then a full generation
        for (int i = 0; i < N; i++) begin
            parent[i] = GB'({$urandom(), $urandom(), $urandom()});
            mask[i]   = GB'({$urandom(), $urandom(), $urandom()});
        end
        wr_cnt[0] = 0;
        wr_cnt[1] = 0;
        push_exp(8);
        maskReady = 1'b1;
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        repeat (16) @(negedge CLOCK_50);
        chk("rst7_in_apply", 128'(wr_en[1]), 128'(1));
        chk("rst7_addr", 128'(wr_addr[1]), 128'(7));
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst7_used_d%0d", d), 128'(mask_used[d]), 128'(0));
            chk($sformatf("rst7_busy_d%0d", d), 128'(busy[d]), 128'(0));
            chk($sformatf("rst7_wr_en_d%0d", d), 128'(wr_en[d]), 128'(0));
        end
        repeat (6) @(negedge CLOCK_50);
        chk("rst7_writes_d0", 128'(wr_cnt[0]), 128'(8));
        chk("rst7_writes_d1", 128'(wr_cnt[1]), 128'(8));
        chk("rst7_q_empty", 128'(q0.size() + q1.size()), 128'(0));
        do_gen("redo", 3, 0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
